// File: rtl/ps2_keyboard_if.sv
// Signal bundle between a PS/2 connector and the Hack keyboard register slot.
// master is the receiver side; slave is the device/consumer side.
interface ps2_keyboard_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] key_code;
  logic        key_event;
  logic        frame_err;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output key_code,
    output key_event,
    output frame_err
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  key_code,
    input  key_event,
    input  frame_err
  );
endinterface

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: filtered frame deserialiser plus scan-code set 2 decoder
// producing a Hack KBD value (held key code, 0 when no key is held).
module ps2_keyboard #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 5000
) (
  input  logic           clk,
  input  logic           reset,
  ps2_keyboard_if.master bus
);

  localparam int unsigned FltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Bit 0 is the clock line, bit 1 the data line.
  logic [1:0]      sync0_q, sync1_q, filt_q;
  logic [FltW-1:0] flt_cnt_q [2];
  logic            clk_prev_q;
  logic            strobe, sdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0_q    <= 2'b11;
      sync1_q    <= 2'b11;
      filt_q     <= 2'b11;
      clk_prev_q <= 1'b1;
      for (int i = 0; i < 2; i++) flt_cnt_q[i] <= '0;
    end else begin
      sync0_q    <= {bus.ps2_data, bus.ps2_clk};
      sync1_q    <= sync0_q;
      clk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync1_q[i] == filt_q[i]) begin
          flt_cnt_q[i] <= '0;
        end else if (flt_cnt_q[i] == FltW'(FILTER_LEN - 1)) begin
          filt_q[i]    <= sync1_q[i];
          flt_cnt_q[i] <= '0;
        end else begin
          flt_cnt_q[i] <= flt_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign strobe = clk_prev_q & ~filt_q[0];
  assign sdata  = filt_q[1];

  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic            err_d, ready_d, byte_ready_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      timer_q      <= '0;
      byte_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      timer_q      <= timer_d;
      byte_ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    timer_d   = timer_q;
    err_d     = 1'b0;
    ready_d   = 1'b0;
    if (strobe) begin
      timer_d = '0;
      unique case (state_q)
        StIdle: begin
          if (!sdata) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          shift_d   = {sdata, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          parity_d = sdata;
          state_d  = StStop;
        end
        StStop: begin
          if (sdata && (^{shift_q, parity_q})) ready_d = 1'b1;
          else                                err_d   = 1'b1;
          state_d = StIdle;
        end
      endcase
    end else if (state_q != StIdle) begin
      if (timer_q == TmrW'(TIMEOUT)) begin
        err_d   = 1'b1;
        state_d = StIdle;
        timer_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  // Set-2 to Hack translation; 0 marks an unmapped code.
  function automatic logic [15:0] xlate(input logic ext, input logic [7:0] b);
    logic [15:0] c;
    c = 16'd0;
    case ({ext, b})
      9'h01C: c = 16'd65;  9'h032: c = 16'd66;  9'h021: c = 16'd67;  9'h023: c = 16'd68;
      9'h024: c = 16'd69;  9'h02B: c = 16'd70;  9'h034: c = 16'd71;  9'h033: c = 16'd72;
      9'h043: c = 16'd73;  9'h03B: c = 16'd74;  9'h042: c = 16'd75;  9'h04B: c = 16'd76;
      9'h03A: c = 16'd77;  9'h031: c = 16'd78;  9'h044: c = 16'd79;  9'h04D: c = 16'd80;
      9'h015: c = 16'd81;  9'h02D: c = 16'd82;  9'h01B: c = 16'd83;  9'h02C: c = 16'd84;
      9'h03C: c = 16'd85;  9'h02A: c = 16'd86;  9'h01D: c = 16'd87;  9'h022: c = 16'd88;
      9'h035: c = 16'd89;  9'h01A: c = 16'd90;
      9'h045: c = 16'd48;  9'h016: c = 16'd49;  9'h01E: c = 16'd50;  9'h026: c = 16'd51;
      9'h025: c = 16'd52;  9'h02E: c = 16'd53;  9'h036: c = 16'd54;  9'h03D: c = 16'd55;
      9'h03E: c = 16'd56;  9'h046: c = 16'd57;
      9'h029: c = 16'd32;  9'h05A: c = 16'd128; 9'h066: c = 16'd129; 9'h076: c = 16'd140;
      9'h16B: c = 16'd130; 9'h175: c = 16'd131; 9'h174: c = 16'd132; 9'h172: c = 16'd133;
      9'h171: c = 16'd139;
      default: c = 16'd0;
    endcase
    return c;
  endfunction

  logic        ext_q, brk_q, key_event_q, frame_err_q;
  logic [15:0] key_code_q, code;

  assign code = xlate(ext_q, shift_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      key_code_q  <= '0;
      key_event_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      key_event_q <= 1'b0;
      frame_err_q <= err_d;
      if (err_d) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (byte_ready_q) begin
        if (shift_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (shift_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (code != 16'd0) begin
            if (!brk_q) begin
              key_code_q  <= code;
              key_event_q <= 1'b1;
            end else if (code == key_code_q) begin
              key_code_q  <= '0;
              key_event_q <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.key_code  = key_code_q;
  assign bus.key_event = key_event_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Scoreboard bench for ps2_keyboard: frames are bit-banged on the PS/2 lines and every
// key_event / frame_err pulse is matched against the queued expectation.
module tb_ps2_keyboard;

  localparam int Half = 40;  // PS/2 half-period in clk cycles

  typedef struct packed {
    logic        is_err;
    logic [15:0] code;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t e;

  always #10 clk = ~clk;

  ps2_keyboard_if kbd ();

  ps2_keyboard #(
    .FILTER_LEN(8),
    .TIMEOUT   (5000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (kbd)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    kbd.ps2_data = b;
    wait_clks(Half);
    kbd.ps2_clk = 1'b0;
    wait_clks(Half);
    kbd.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    kbd.ps2_data = 1'b1;
    wait_clks(2 * Half);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  task automatic expect_key(input logic [15:0] c);
    exp_t x;
    x.is_err = 1'b0;
    x.code   = c;
    exp_q.push_back(x);
  endtask

  task automatic expect_err();
    exp_t x;
    x.is_err = 1'b1;
    x.code   = 16'd0;
    exp_q.push_back(x);
  endtask

  task automatic check_key(input string tag, input logic [15:0] c);
    @(negedge clk);
    check_eq(tag, kbd.key_code, c);
  endtask

  initial begin
    kbd.ps2_clk  = 1'b1;
    kbd.ps2_data = 1'b1;
    reset        = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (!reset && (kbd.key_event || kbd.frame_err)) begin
          check_eq("event_excl", kbd.key_event & kbd.frame_err, 0);
          check_eq("sb_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("ev_kind", kbd.frame_err, e.is_err);
            if (!e.is_err) check_eq("ev_code", kbd.key_code, e.code);
          end
        end
      end
    join_none

    wait_clks(5);
    @(negedge clk);
    check_eq("rst_key_code", kbd.key_code, 0);
    check_eq("rst_key_event", kbd.key_event, 0);
    check_eq("rst_frame_err", kbd.frame_err, 0);
    reset = 1'b0;
    wait_clks(20);

    // Press and release A
    expect_key(16'd65); send(8'h1C);
    check_key("press_A", 16'd65);
    expect_key(16'd0); send(8'hF0); send(8'h1C);
    check_key("release_A", 16'd0);

    // Extended left arrow, both prefix orders, then bare 6B ignored
    expect_key(16'd130); send(8'hE0); send(8'h6B);
    check_key("press_left", 16'd130);
    expect_key(16'd0); send(8'hE0); send(8'hF0); send(8'h6B);
    check_key("release_left", 16'd0);
    send(8'h6B);
    check_key("bare_6B", 16'd0);
    expect_key(16'd130); send(8'hE0); send(8'h6B);
    expect_key(16'd0); send(8'hF0); send(8'hE0); send(8'h6B);
    check_key("release_left_f0e0", 16'd0);

    // Overlapping keys: releasing a non-current key leaves key_code alone
    expect_key(16'd65); send(8'h1C);
    expect_key(16'd66); send(8'h32);
    send(8'hF0); send(8'h1C);
    check_key("stale_release", 16'd66);
    expect_key(16'd0); send(8'hF0); send(8'h32);
    check_key("release_B", 16'd0);

    // Frame errors leave key_code unchanged
    expect_key(16'd65); send(8'h1C);
    expect_err(); send_frame(8'h1C, 1'b1, 1'b0);
    check_key("bad_parity", 16'd65);
    expect_err(); send_frame(8'h32, 1'b0, 1'b1);
    check_key("bad_stop", 16'd65);
    expect_err();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    wait_clks(5200);
    kbd.ps2_data = 1'b1;
    wait_clks(20);
    check_key("timeout", 16'd65);
    check_eq("sb_after_timeout", exp_q.size(), 0);

    // Space, then a typematic repeat
    expect_key(16'd32); send(8'h29);
    check_key("press_space", 16'd32);
    expect_key(16'd32); send(8'h29);
    check_key("repeat_space", 16'd32);

    // Short clk glitch with data low must not start a frame (no later timeout)
    kbd.ps2_data = 1'b0;
    wait_clks(20);
    kbd.ps2_clk = 1'b0;
    wait_clks(4);
    kbd.ps2_clk = 1'b1;
    wait_clks(20);
    kbd.ps2_data = 1'b1;
    wait_clks(5200);
    check_key("glitch", 16'd32);

    // Reset during bit 4 of a frame
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    kbd.ps2_data = 1'b0;
    wait_clks(Half);
    kbd.ps2_clk = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("reset_midframe", kbd.key_code, 0);
    wait_clks(5);
    kbd.ps2_clk  = 1'b1;
    kbd.ps2_data = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_clks(40);
    expect_key(16'd65); send(8'h1C);
    check_key("post_reset_A", 16'd65);

    // Repeated prefix keeps ext set
    expect_key(16'd131); send(8'hE0); send(8'hE0); send(8'h75);
    check_key("double_e0_up", 16'd131);

    wait_clks(50);
    check_eq("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
